// File: rtl/systolic_mul_ctrl.sv
// systolic_mul_ctrl
// Sequencer for the 4x4 systolic multiplier array. Holds operand matrices A
// and B in local register buffers, then on start clears the array, streams
// the diagonally skewed operands into its left/up edges, waits for the
// array's done and reports completion or timeout to the host.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   wr_en_i, wr_sel_i        buffer write strobe, 0 = A buffer, 1 = B buffer
//   wr_addr_i, wr_data_i     element index (row*4+col) and value
//   start_i                  start pulse, honoured only when idle
//   done_i                   done from the array
//   busy_o                   high whenever not idle
//   done_o                   one-cycle completion pulse
//   err_o                    sticky timeout flag, cleared by the next start
//   arr_rst_no               drives the array's rst_ni
//   left_o_0/4/8/12          row operand streams (rows 0..3)
//   up_o_0..3                column operand streams (columns 0..3)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | buffers writable, array out of reset, waiting for start_i
// CLEAR | one cycle of array reset to clear the accumulators
// FEED  | seven skewed operand slots, k = 0..6
// WAIT  | operands held at 0, waiting for done_i or the timeout
// DONE  | one-cycle done_o pulse, array results left intact

module systolic_mul_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  arr_rst_no,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_4,
  output logic [DATA_WIDTH-1:0] left_o_8,
  output logic [DATA_WIDTH-1:0] left_o_12,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST_SLOT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;

  logic [2:0]            feed_cnt;
  logic [WCW-1:0]        wait_cnt;
  logic [WCW-1:0]        wait_nxt;
  logic [2:0]            slot;

  logic [DATA_WIDTH-1:0] a_buf    [16];
  logic [DATA_WIDTH-1:0] b_buf    [16];
  logic [DATA_WIDTH-1:0] left_q   [4];
  logic [DATA_WIDTH-1:0] up_q     [4];
  logic [DATA_WIDTH-1:0] left_nxt [4];
  logic [DATA_WIDTH-1:0] up_nxt   [4];

  // Operand buffers are deliberately not reset; writes only land while idle
  // so a running sequence always sees a stable matrix.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en_i && (state == S_IDLE)) begin
      if (wr_sel_i) b_buf[wr_addr_i] <= wr_data_i;
      else          a_buf[wr_addr_i] <= wr_data_i;
    end
  end

  // Slot whose values get loaded at the coming edge: CLEAR preloads slot 0,
  // FEED slot k preloads slot k+1.
  always_comb begin
    slot = 3'd0;
    if (state == S_FEED) slot = feed_cnt + 3'd1;
  end

  // Skew: row r carries A[r][slot-r], column c carries B[slot-c][c];
  // anything outside the 4-wide window is zero.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      left_nxt[r] = '0;
      up_nxt[r]   = '0;
      for (int j = 0; j < 4; j++) begin
        if (int'(slot) == r + j) begin
          left_nxt[r] = a_buf[4'(r * 4 + j)];
          up_nxt[r]   = b_buf[4'(j * 4 + r)];
        end
      end
    end
  end

  // Saturating so the counter can never wrap back under the limit.
  always_comb begin
    wait_nxt = wait_cnt;
    if (wait_cnt != WCW'(TIMEOUT)) wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      arr_rst_no <= 1'b0;
      feed_cnt   <= '0;
      wait_cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        left_q[i] <= '0;
        up_q[i]   <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          arr_rst_no <= 1'b1;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
          if (start_i) begin
            state      <= S_CLEAR;
            busy_o     <= 1'b1;
            err_o      <= 1'b0;
            arr_rst_no <= 1'b0;
          end
        end

        S_CLEAR: begin
          state      <= S_FEED;
          arr_rst_no <= 1'b1;
          feed_cnt   <= '0;
          wait_cnt   <= '0;
          for (int i = 0; i < 4; i++) begin
            left_q[i] <= left_nxt[i];
            up_q[i]   <= up_nxt[i];
          end
        end

        S_FEED: begin
          if (feed_cnt == LAST_SLOT) begin
            state <= S_WAIT;
            for (int i = 0; i < 4; i++) begin
              left_q[i] <= '0;
              up_q[i]   <= '0;
            end
          end else begin
            feed_cnt <= feed_cnt + 3'd1;
            for (int i = 0; i < 4; i++) begin
              left_q[i] <= left_nxt[i];
              up_q[i]   <= up_nxt[i];
            end
          end
        end

        S_WAIT: begin
          wait_cnt <= wait_nxt;
          // done_i is checked first so a late done on the timeout cycle
          // still counts as a clean completion.
          if (done_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (wait_nxt == WCW'(TIMEOUT)) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  assign left_o_0  = left_q[0];
  assign left_o_4  = left_q[1];
  assign left_o_8  = left_q[2];
  assign left_o_12 = left_q[3];
  assign up_o_0    = up_q[0];
  assign up_o_1    = up_q[1];
  assign up_o_2    = up_q[2];
  assign up_o_3    = up_q[3];

endmodule
